// File: rtl/dice_pkg.sv
// Shared types, constants and helpers for the dice roll sequencer.
// Face arithmetic and the LFSR step live here so every user agrees on them.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int          FACE_W    = 3;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] value);
    return {value[14:0], ^(value & LFSR_TAPS)};
  endfunction

  // Offset is 1..faces-1 so the new face never equals the current one
  function automatic logic [FACE_W-1:0] next_face(input logic [FACE_W-1:0] cur,
                                                  input logic [2:0]        rnd,
                                                  input int                faces);
    int sum;
    sum = int'(cur) + 1 + (int'(rnd) % (faces - 1));
    if (sum >= faces) sum = sum - faces;
    return FACE_W'(sum);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes the raw active-low button and accepts a level change only
// after it has been stable for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // press pulses on the same edge the debounced level falls to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/dice_roll_sequencer.sv
// Push-button dice: debounced press starts a decelerating roll of
// pseudo-random faces, then settles and holds until the button is released.
module dice_roll_sequencer
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int STEP_BASE       = 600000,
  parameter int STEP_INC        = 150000,
  parameter int NUM_STEPS       = 16,
  parameter int FACES           = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_n,
  output logic [FACE_W-1:0] face,
  output logic              rolling,
  output logic              done
);

  localparam int MAX_INTERVAL = STEP_BASE + (NUM_STEPS - 1) * STEP_INC;
  localparam int TIMER_W      = $clog2(MAX_INTERVAL);
  localparam int STEP_W       = $clog2(NUM_STEPS);

  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(NUM_STEPS - 1);
  localparam logic [TIMER_W-1:0] LIMIT_BASE = TIMER_W'(STEP_BASE - 1);
  localparam logic [TIMER_W-1:0] LIMIT_INC  = TIMER_W'(STEP_INC);

  logic w_level;
  logic w_press;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clk),
    .rst_n(rst_n),
    .btn_n(btn_n),
    .level(w_level),
    .press(w_press)
  );

  state_t              r_state,   w_state;
  logic [FACE_W-1:0]   r_face,    w_face;
  logic                r_rolling, w_rolling;
  logic                r_done,    w_done;
  logic [TIMER_W-1:0]  r_timer,   w_timer;
  logic [TIMER_W-1:0]  r_limit,   w_limit;
  logic [STEP_W-1:0]   r_step,    w_step;
  logic [15:0]         r_lfsr;

  // r_limit tracks interval(step)-1 incrementally, avoiding a multiplier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_face    <= '0;
      r_rolling <= 1'b0;
      r_done    <= 1'b0;
      r_timer   <= '0;
      r_limit   <= '0;
      r_step    <= '0;
      r_lfsr    <= LFSR_SEED;
    end else begin
      r_state   <= w_state;
      r_face    <= w_face;
      r_rolling <= w_rolling;
      r_done    <= w_done;
      r_timer   <= w_timer;
      r_limit   <= w_limit;
      r_step    <= w_step;
      r_lfsr    <= lfsr_step(r_lfsr);
    end
  end

  always_comb begin
    w_state   = r_state;
    w_face    = r_face;
    w_rolling = r_rolling;
    w_done    = 1'b0;
    w_timer   = r_timer;
    w_limit   = r_limit;
    w_step    = r_step;

    case (r_state)
      IDLE: begin
        if (w_press) begin
          w_state   = ROLL;
          w_rolling = 1'b1;
          w_timer   = '0;
          w_step    = '0;
          w_limit   = LIMIT_BASE;
        end
      end
      ROLL: begin
        if (r_timer == r_limit) begin
          w_face  = next_face(r_face, r_lfsr[2:0], FACES);
          w_timer = '0;
          if (r_step == STEP_LAST) begin
            w_state   = HOLD;
            w_rolling = 1'b0;
            w_done    = 1'b1;
          end else begin
            w_step  = r_step + STEP_W'(1);
            w_limit = r_limit + LIMIT_INC;
          end
        end else begin
          w_timer = r_timer + TIMER_W'(1);
        end
      end
      HOLD: begin
        // Wait for release so a held button cannot auto-repeat
        if (w_level) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  assign face    = r_face;
  assign rolling = r_rolling;
  assign done    = r_done;

endmodule
